alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that shares the single 64-bit execution ALU between two requesters, such as two issue slots or an integer pipe and an address-generation pipe. It picks one request per cycle by round-robin and drives the ALU's `opcode`/`a`/`b` inputs combinationally. It captures the ALU result into a one-entry response register with a valid/ready handshake. It also screens opcodes against the legal ALU encoding set, because the ALU holds its previous output on unknown opcodes.

---
 rtl/alu_share_arb.sv | 147 ++++++++++++++
 tb/tb_alu_share_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one 64-bit ALU between two requesters,
// with opcode screening and a one-entry registered response (valid/ready).
// Latency: a request accepted in cycle N has its response valid in cycle N+1.
// Backpressure: while the response is held and rsp_ready=0, both req ready outputs are 0.
// Ports:
//   clk, rst                                 - clock, synchronous active-high reset
//   reqN_valid/ready/opcode/a/b (N = 0, 1)   - requester operation handshake and operands
//   alu_opcode/alu_a/alu_b, alu_out          - drive to / result from the shared combinational ALU
//   rsp_valid/ready/id/data/err              - registered response handshake and payload
module alu_share_arb #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [9:0]        req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [9:0]        req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic [9:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    // Opcode the ALU is parked on when nothing is granted.
    localparam logic [9:0] IDLE_OP = 10'h100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t        r_state;
    rsp_state_t        w_state_nxt;
    logic              r_prio;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic              w_can_accept;
    logic              w_win0;
    logic              w_win1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_grant;
    logic              w_legal;

    // The ALU holds its previous output on unknown opcodes, so its result is
    // only trusted for this fixed set.
    function automatic logic is_legal(input logic [9:0] op);
        case (op)
            10'h100, 10'h101, 10'h104, 10'h105, 10'h106, 10'h107,
            10'h200, 10'h204, 10'h206, 10'h207, 10'h300: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    // Nothing is accepted while reset is asserted, even though the state
    // register still shows its pre-reset contents during that cycle.
    assign w_can_accept = !rst && ((r_state == ST_EMPTY) || rsp_ready);

    // A lone request wins outright; on a tie the priority pointer decides.
    assign w_win0   = req0_valid && (!req1_valid || (r_prio == 1'b0));
    assign w_win1   = req1_valid && (!req0_valid || (r_prio == 1'b1));
    assign w_grant0 = w_can_accept && w_win0;
    assign w_grant1 = w_can_accept && w_win1;
    assign w_grant  = w_grant0 || w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        alu_opcode = IDLE_OP;
        alu_a      = '0;
        alu_b      = '0;
        if (w_grant1) begin
            alu_opcode = req1_opcode;
            alu_a      = req1_a;
            alu_b      = req1_b;
        end else if (w_grant0) begin
            alu_opcode = req0_opcode;
            alu_a      = req0_a;
            alu_b      = req0_b;
        end
    end

    assign w_legal = is_legal(alu_opcode);

    // Response register occupancy: a grant always fills it (overwriting a
    // result drained in the same cycle); a drain without a grant empties it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !w_grant) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_prio     <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rsp_id   <= w_grant1;
                r_rsp_data <= w_legal ? alu_out : '0;
                r_rsp_err  <= !w_legal;
                // Loser of this round gets priority on the next tie.
                r_prio     <= !w_grant1;
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready;
    logic [9:0]        req0_opcode;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic              req1_valid, req1_ready;
    logic [9:0]        req1_opcode;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [9:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [DATA_W-1:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_opcode(req0_opcode),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_opcode(req1_opcode),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // Simple combinational ALU stand-in; unknown opcodes give a recognisable
    // garbage value so a leaked result would show up in rsp_data.
    always_comb begin
        case (alu_opcode)
            10'h200: alu_out = alu_a + alu_b;
            10'h300: alu_out = alu_a - alu_b;
            10'h104: alu_out = alu_a ^ alu_b;
            10'h106: alu_out = alu_a | alu_b;
            10'h107: alu_out = alu_a & alu_b;
            10'h100: alu_out = alu_a + alu_b;
            default: alu_out = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        rsp_ready   = 1'b0;
        req0_valid  = 1'b1;
        req0_opcode = 10'h300;
        req0_a      = 64'd10;
        req0_b      = 64'd3;
        req1_valid  = 1'b1;
        req1_opcode = 10'h300;
        req1_a      = 64'd1;
        req1_b      = 64'd1;

        // Reset with both requests pending: nothing accepted, ALU idle.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_rdy0",   {63'd0, req0_ready}, 64'd0);
            chk("rst_rdy1",   {63'd0, req1_ready}, 64'd0);
            chk("rst_aluop",  {54'd0, alu_opcode}, 64'h100);
            chk("rst_valid",  {63'd0, rsp_valid},  64'd0);
            chk("rst_data",   rsp_data,            64'd0);
        end

        // Single op: 10 - 3 = 7 on requester 0.
        rst        = 1'b0;
        rsp_ready  = 1'b1;
        req1_valid = 1'b0;
        #1;
        chk("single_rdy0",  {63'd0, req0_ready}, 64'd1);
        chk("single_rdy1",  {63'd0, req1_ready}, 64'd0);
        chk("single_aluop", {54'd0, alu_opcode}, 64'h300);
        step();
        req0_valid = 1'b0;
        chk("single_valid", {63'd0, rsp_valid}, 64'd1);
        chk("single_id",    {63'd0, rsp_id},    64'd0);
        chk("single_data",  rsp_data,           64'd7);
        chk("single_err",   {63'd0, rsp_err},   64'd0);

        // Re-reset so the priority pointer starts at requester 0.
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Fair sharing: 5+1 on req0, 0xF^0x3 on req1, grants alternate 0,1,0,1.
        req0_valid  = 1'b1;
        req0_opcode = 10'h200;
        req0_a      = 64'd5;
        req0_b      = 64'd1;
        req1_valid  = 1'b1;
        req1_opcode = 10'h104;
        req1_a      = 64'hF;
        req1_b      = 64'h3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fair_rdy0", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("fair_rdy1", {63'd0, req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
            step();
            chk("fair_valid", {63'd0, rsp_valid}, 64'd1);
            chk("fair_id",    {63'd0, rsp_id},    (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("fair_data",  rsp_data,           (i % 2 == 1) ? 64'hC : 64'd6);
        end

        // Back-pressure: register holds req1's 0xC, nothing is granted.
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_rdy0",  {63'd0, req0_ready}, 64'd0);
            chk("bp_rdy1",  {63'd0, req1_ready}, 64'd0);
            chk("bp_aluop", {54'd0, alu_opcode}, 64'h100);
            step();
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_id",    {63'd0, rsp_id},    64'd1);
            chk("bp_data",  rsp_data,           64'hC);
        end
        // Release: drain plus new grant; priority still with requester 0.
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("bp_rel_rdy1", {63'd0, req1_ready}, 64'd0);
        step();
        chk("bp_rel_valid", {63'd0, rsp_valid}, 64'd1);
        chk("bp_rel_id",    {63'd0, rsp_id},    64'd0);
        chk("bp_rel_data",  rsp_data,           64'd6);

        // Illegal opcode on requester 1.
        req0_valid  = 1'b0;
        req1_opcode = 10'h3FF;
        req1_a      = 64'd1;
        req1_b      = 64'd1;
        #1;
        chk("ill_rdy1",  {63'd0, req1_ready}, 64'd1);
        chk("ill_aluop", {54'd0, alu_opcode}, 64'h3FF);
        step();
        req1_valid = 1'b0;
        #1;
        chk("ill_aluop_after", {54'd0, alu_opcode}, 64'h100);
        chk("ill_valid", {63'd0, rsp_valid}, 64'd1);
        chk("ill_err",   {63'd0, rsp_err},   64'd1);
        chk("ill_data",  rsp_data,           64'd0);
        chk("ill_id",    {63'd0, rsp_id},    64'd1);
        step();
        chk("drain_valid", {63'd0, rsp_valid}, 64'd0);

        // Reset mid-operation: grant req0 alone (priority moves to 1), hold, reset.
        req0_valid  = 1'b1;
        req0_opcode = 10'h200;
        req0_a      = 64'd2;
        req0_b      = 64'd2;
        step();
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        chk("mid_data", rsp_data, 64'd4);
        step();
        chk("mid_hold", {63'd0, rsp_valid}, 64'd1);
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_opcode = 10'h200;
        #1;
        chk("mid_rst_rdy0", {63'd0, req0_ready}, 64'd0);
        chk("mid_rst_rdy1", {63'd0, req1_ready}, 64'd0);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        chk("mid_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_data0", rsp_data,           64'd0);
        #1;
        chk("mid_tie_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("mid_tie_rdy1", {63'd0, req1_ready}, 64'd0);
        step();
        chk("mid_tie_id",   {63'd0, rsp_id}, 64'd0);
        chk("mid_tie_data", rsp_data,        64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
